// File: rtl/nbit_universal_shreg.sv
// Universal N-bit shift register (hold / shift right / shift left / load) with a per-frame shift counter.
// Latency: one cycle from input sampling to q; no backpressure, every edge acts on mode.
module nbit_universal_shreg #(
    parameter  int NBIT = 5,
    localparam int CNTW = $clog2(NBIT + 1)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [1:0]      mode,
    input  logic            ser_in_msb,
    input  logic            ser_in_lsb,
    input  logic [NBIT-1:0] pin,
    output logic [NBIT-1:0] q,
    output logic            ser_out_lsb,
    output logic            ser_out_msb,
    output logic [CNTW-1:0] bit_cnt,
    output logic            frame_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NBIT - 1);

    logic [NBIT-1:0] q_q, q_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            shift;

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        shift  = 1'b0;
        case (mode)
            MODE_HOLD: begin
            end
            MODE_RIGHT: begin
                q_d   = {ser_in_msb, q_q[NBIT-1:1]};
                shift = 1'b1;
            end
            MODE_LEFT: begin
                q_d   = {q_q[NBIT-2:0], ser_in_lsb};
                shift = 1'b1;
            end
            MODE_LOAD: begin
                q_d   = pin;
                cnt_d = '0;
            end
            default: begin
            end
        endcase

        // Direction-agnostic count; the wrapping shift still moves data.
        if (shift) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q           = q_q;
    assign bit_cnt     = cnt_q;
    assign frame_done  = done_q;
    assign ser_out_lsb = q_q[0];
    assign ser_out_msb = q_q[NBIT-1];

endmodule

// File: tb/tb_nbit_universal_shreg.sv
// Bench for nbit_universal_shreg at NBIT=5 and NBIT=8 driven by a shared stimulus stream.
module tb_nbit_universal_shreg;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr;
    logic [1:0] mode;
    logic       smsb, slsb;
    logic [4:0] pin5;
    logic [7:0] pin8;

    logic [4:0] q5;
    logic       lsb5, msb5, fd5;
    logic [2:0] cnt5;
    logic [7:0] q8;
    logic       lsb8, msb8, fd8;
    logic [3:0] cnt8;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: register value, shifts taken in current frame, pulse.
    int mq5 = 0, ms5 = 0, mq8 = 0, ms8 = 0;
    bit mf5 = 1'b0, mf8 = 1'b0;

    nbit_universal_shreg #(.NBIT(5)) dut5 (
        .clk(clk), .clr(clr), .mode(mode), .ser_in_msb(smsb), .ser_in_lsb(slsb),
        .pin(pin5), .q(q5), .ser_out_lsb(lsb5), .ser_out_msb(msb5),
        .bit_cnt(cnt5), .frame_done(fd5)
    );

    nbit_universal_shreg #(.NBIT(8)) dut8 (
        .clk(clk), .clr(clr), .mode(mode), .ser_in_msb(smsb), .ser_in_lsb(slsb),
        .pin(pin8), .q(q8), .ser_out_lsb(lsb8), .ser_out_msb(msb8),
        .bit_cnt(cnt8), .frame_done(fd8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int n, input bit clr_v, input logic [1:0] m,
                              input logic si_msb, input logic si_lsb, input int p,
                              inout int mq, inout int ms, inout bit mf);
        int full;
        full = (1 << n) - 1;
        if (!clr_v) begin
            mq = 0; ms = 0; mf = 1'b0;
        end else if (m == 2'b11) begin
            mq = p & full; ms = 0; mf = 1'b0;
        end else if (m == 2'b00) begin
            mf = 1'b0;
        end else begin
            if (m == 2'b01) mq = (mq >> 1) + (int'(si_msb) << (n - 1));
            else            mq = ((mq * 2) + int'(si_lsb)) & full;
            ms = ms + 1;
            mf = (ms == n);
            if (mf) ms = 0;
        end
    endtask

    task automatic step(input bit clr_v, input logic [1:0] m, input logic sm,
                        input logic sl, input logic [7:0] p);
        clr  = clr_v;
        mode = m;
        smsb = sm;
        slsb = sl;
        pin5 = p[4:0];
        pin8 = p;
        model_edge(5, clr_v, m, sm, sl, int'(p), mq5, ms5, mf5);
        model_edge(8, clr_v, m, sm, sl, int'(p), mq8, ms8, mf8);
        @(posedge clk);
        #1;
        chk("q5",    q5,   mq5);
        chk("cnt5",  cnt5, ms5);
        chk("fd5",   fd5,  mf5);
        chk("lsb5",  lsb5, mq5 & 1);
        chk("msb5",  msb5, (mq5 >> 4) & 1);
        chk("q8",    q8,   mq8);
        chk("cnt8",  cnt8, ms8);
        chk("fd8",   fd8,  mf8);
        chk("lsb8",  lsb8, mq8 & 1);
        chk("msb8",  msb8, (mq8 >> 7) & 1);
    endtask

    initial begin
        logic [4:0] exp_q2 [5];
        logic       bits2  [5];
        logic [1:0] m;
        logic [7:0] p;
        bit         c;
        exp_q2 = '{5'b10000, 5'b11000, 5'b01100, 5'b10110, 5'b01011};
        bits2  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset wins over a simultaneous load.
        step(1'b0, 2'b11, 1'b0, 1'b0, 8'hFF);
        chk("rst_q5", q5, 0);
        chk("rst_cnt5", cnt5, 0);
        chk("rst_fd5", fd5, 0);

        // Right-shift frame; unused left serial input held at X.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b01, bits2[i], 1'bx, 8'h00);
            chk("s2_q", q5, exp_q2[i]);
            chk("s2_cnt", cnt5, (i + 1) % 5);
            chk("s2_fd", fd5, (i == 4) ? 1 : 0);
        end
        chk("s2_lsb", lsb5, 1);

        // Load then left shift.
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'b0001_0110);
        chk("s3_load", q5, 5'b10110);
        chk("s3_cnt0", cnt5, 0);
        step(1'b1, 2'b10, 1'bx, 1'b1, 8'h00);
        chk("s3_q", q5, 5'b01101);
        chk("s3_msb", msb5, 0);
        chk("s3_cnt", cnt5, 1);

        // Hold inside a frame pauses the count.
        step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF);
            chk("s4_hold_cnt", cnt5, 2);
            chk("s4_hold_fd", fd5, 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, (i == 1) ? 2'b10 : 2'b01, 1'b1, 1'b0, 8'h00);
            chk("s4_fd", fd5, (i == 2) ? 1 : 0);
        end

        // Reset mid-frame discards the partial count.
        for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
        step(1'b0, 2'b01, 1'b1, 1'b0, 8'h00);
        chk("s5_rst_q", q5, 0);
        chk("s5_rst_cnt", cnt5, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 2'b01, 1'b1, 1'b0, 8'h00);
            chk("s5_fd", fd5, (i == 4) ? 1 : 0);
        end

        // Continuous shifting: pulses every 5 (and every 8) shifts.
        step(1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'b01, 1'($urandom_range(0, 1)), 1'bx, 8'h00);
            chk("s6_fd5", fd5, ((i + 1) % 5 == 0) ? 1 : 0);
            chk("s6_fd8", fd8, ((i + 1) % 8 == 0) ? 1 : 0);
            chk("s6_cnt8", cnt8, (i + 1) % 8);
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            c = ($urandom_range(0, 19) != 0);
            m = 2'($urandom_range(0, 3));
            p = 8'($urandom);
            if (m == 2'b01)      step(c, m, 1'($urandom_range(0, 1)), 1'bx, p);
            else if (m == 2'b10) step(c, m, 1'bx, 1'($urandom_range(0, 1)), p);
            else                 step(c, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
